// File: rtl/mon_rx_parser.sv
// mon_rx_parser: pops bytes from the monitor UART receive FIFO, accumulates
// ASCII hex digits into a 32-bit word and reports command characters, line
// ends and illegal control bytes to the monitor controller.
// Optional feature macro: MON_RX_ECHO_EN (echo every received byte to the
// transmit FIFO, CR expanded to CR LF).
module mon_rx_parser #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_fifo_dvalid,
  input  logic [7:0]  rx_rdata,
  output logic        rx_rden,
  input  logic        tx_fifo_full,
  output logic [7:0]  tx_wdata,
  output logic        tx_wten,
  output logic [31:0] data_word,
  output logic [3:0]  data_ndigits,
  output logic        data_valid,
  output logic [7:0]  cmd_char,
  output logic        cmd_valid,
  output logic        line_end,
  output logic        parse_err
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  typedef enum logic [2:0] {IDLE, FETCH, POP, PARSE, ECHO, ECHO_LF} state_t;

  state_t      state, state_nx;
  logic [7:0]  byte_r;
  logic [31:0] acc;
  logic [3:0]  ndig;
  logic        hex_ok;
  logic [3:0]  hex_nib;
  logic        is_term;
  logic        is_cmd;

`ifndef MON_RX_ECHO_EN
  // The transmit side is idle without echo; keep the input visibly consumed.
  logic unused_tx_full;
  assign unused_tx_full = tx_fifo_full;
`endif

  // Classify the captured byte: hex digit value, terminator, command char.
  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'h0;
    if (byte_r >= 8'h30 && byte_r <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_nib = byte_r[3:0];
    end else if ((byte_r >= 8'h41 && byte_r <= 8'h46) ||
                 (byte_r >= 8'h61 && byte_r <= 8'h66)) begin
      hex_ok  = 1'b1;
      hex_nib = byte_r[3:0] + 4'd9;
    end
    is_term = (byte_r == 8'h20) || (byte_r == 8'h0D) || (byte_r == 8'h0A);
    is_cmd  = (byte_r >= 8'h21) && (byte_r <= 8'h7E);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and strobes; strobes are masked during reset so a pending
  // pop or echo is abandoned cleanly.
  always_comb begin
    state_nx = state;
    rx_rden  = 1'b0;
    tx_wten  = 1'b0;
    tx_wdata = 8'h00;
    case (state)
      IDLE:  if (rx_fifo_dvalid) state_nx = FETCH;
      FETCH: state_nx = POP;
      POP: begin
        rx_rden  = rst_n;
        state_nx = PARSE;
      end
`ifdef MON_RX_ECHO_EN
      PARSE: state_nx = ECHO;
      ECHO: begin
        if (!tx_fifo_full) begin
          tx_wten  = rst_n;
          tx_wdata = byte_r;
          state_nx = (byte_r == 8'h0D) ? ECHO_LF : IDLE;
        end
      end
      ECHO_LF: begin
        if (!tx_fifo_full) begin
          tx_wten  = rst_n;
          tx_wdata = 8'h0A;
          state_nx = IDLE;
        end
      end
`else
      PARSE: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Byte capture, digit accumulator and registered result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_r       <= 8'h00;
      acc          <= 32'h0;
      ndig         <= 4'h0;
      data_word    <= 32'h0;
      data_ndigits <= 4'h0;
      data_valid   <= 1'b0;
      cmd_char     <= 8'h00;
      cmd_valid    <= 1'b0;
      line_end     <= 1'b0;
      parse_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      line_end   <= 1'b0;
      parse_err  <= 1'b0;
      if (state == POP) byte_r <= rx_rdata;
      if (state == PARSE) begin
        if (hex_ok) begin
          // Older digits fall off the top; the count saturates.
          acc <= {acc[27:0], hex_nib};
          if (ndig < MAXD) ndig <= ndig + 4'd1;
        end else if (is_term) begin
          if (ndig != 4'h0) begin
            data_word    <= acc;
            data_ndigits <= ndig;
            data_valid   <= 1'b1;
          end
          acc      <= 32'h0;
          ndig     <= 4'h0;
          line_end <= (byte_r == 8'h0D);
        end else if (is_cmd) begin
          // A command discards any half-typed number.
          cmd_char  <= byte_r;
          cmd_valid <= 1'b1;
          acc       <= 32'h0;
          ndig      <= 4'h0;
        end else begin
          parse_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mon_rx_parser.sv
// Self-checking bench for mon_rx_parser: a queue-based receive FIFO, a
// byte-level reference model of the parser results, directed scenarios with
// literal expectations and a randomized byte stream.
module tb_mon_rx_parser;

  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_fifo_dvalid = 1'b0;
  logic [7:0]  rx_rdata = 8'h00;
  logic        rx_rden;
  logic        tx_fifo_full = 1'b0;
  logic [7:0]  tx_wdata;
  logic        tx_wten;
  logic [31:0] data_word;
  logic [3:0]  data_ndigits;
  logic        data_valid;
  logic [7:0]  cmd_char;
  logic        cmd_valid;
  logic        line_end;
  logic        parse_err;

  mon_rx_parser #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_fifo_dvalid(rx_fifo_dvalid), .rx_rdata(rx_rdata), .rx_rden(rx_rden),
    .tx_fifo_full(tx_fifo_full), .tx_wdata(tx_wdata), .tx_wten(tx_wten),
    .data_word(data_word), .data_ndigits(data_ndigits), .data_valid(data_valid),
    .cmd_char(cmd_char), .cmd_valid(cmd_valid), .line_end(line_end),
    .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- receive FIFO model ----------------
  logic [7:0] fifo_q[$];
  bit         pop_pend = 1'b0;

  always @(negedge clk) begin
    #1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pend       = rx_rden;
    rx_fifo_dvalid = (fifo_q.size() > 0);
    rx_rdata       = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          dv, le, cv, pe;
    logic [31:0] word;
    logic [3:0]  nd;
    logic [7:0]  cmd;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  nib_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  tx_log[$];
  logic [31:0] m_word = 0;
  logic [3:0]  m_nd = 0;
  logic [7:0]  m_cmd = 0;
  int          ncyc = 0;
  int          last_rden = -100;
  int cnt_rden = 0, cnt_dv = 0, cnt_cv = 0, cnt_pe = 0, cnt_le = 0, cnt_tx = 0;
  logic [31:0] last_word = 0;
  logic [3:0]  last_nd = 0;
  logic [7:0]  last_cmd = 0;
  bit          last_dv_le = 0;

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    logic [31:0] v;
    e = '{due: ncyc + 2, dv: 0, le: 0, cv: 0, pe: 0, word: 0, nd: 0, cmd: 0};
    if (b inside {[8'h30:8'h39]}) nib_q.push_back(4'(b - 8'h30));
    else if (b inside {[8'h61:8'h66]}) nib_q.push_back(4'(b - 8'h57));
    else if (b inside {[8'h41:8'h46]}) nib_q.push_back(4'(b - 8'h37));
    else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
      if (nib_q.size() > 0) begin
        v = 0;
        foreach (nib_q[i]) v = (v << 4) | 32'(nib_q[i]);
        e.dv = 1; e.word = v;
        e.nd = (nib_q.size() < MAXD) ? 4'(nib_q.size()) : 4'(MAXD);
      end
      e.le = (b == 8'h0D);
      nib_q.delete();
    end else if (b inside {[8'h21:8'h7E]}) begin
      e.cv = 1; e.cmd = b;
      nib_q.delete();
    end else e.pe = 1;
    exp_q.push_back(e);
    tx_exp.push_back(b);
    if (b == 8'h0D) tx_exp.push_back(8'h0A);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    exp_t cur;
    bit e_dv, e_le, e_cv, e_pe;
    #2;
    ncyc++;
    if (!rst_n) begin
      exp_q.delete(); nib_q.delete(); tx_exp.delete();
      m_word = 0; m_nd = 0; m_cmd = 0; last_rden = -100;
    end else begin
      e_dv = 0; e_le = 0; e_cv = 0; e_pe = 0;
      if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
        cur = exp_q.pop_front();
        e_dv = cur.dv; e_le = cur.le; e_cv = cur.cv; e_pe = cur.pe;
        if (cur.dv) begin m_word = cur.word; m_nd = cur.nd; end
        if (cur.cv) m_cmd = cur.cmd;
      end
      chk("data_valid", data_valid, e_dv);
      chk("line_end", line_end, e_le);
      chk("cmd_valid", cmd_valid, e_cv);
      chk("parse_err", parse_err, e_pe);
      chk("data_word", data_word, m_word);
      chk("data_ndigits", data_ndigits, m_nd);
      chk("cmd_char", cmd_char, m_cmd);
      if (data_valid) begin cnt_dv++; last_word = data_word; last_nd = data_ndigits; last_dv_le = line_end; end
      if (cmd_valid) begin cnt_cv++; last_cmd = cmd_char; end
      if (parse_err) cnt_pe++;
      if (line_end) cnt_le++;
`ifdef MON_RX_ECHO_EN
      if (tx_wten) begin
        cnt_tx++;
        tx_log.push_back(tx_wdata);
        chk("tx_while_full", tx_fifo_full, 0);
        if (tx_exp.size() == 0) chk("tx_unexpected", tx_wten, 0);
        else chk("tx_wdata", tx_wdata, tx_exp.pop_front());
      end
`else
      chk("tx_wten_off", tx_wten, 0);
      chk("tx_wdata_off", tx_wdata, 0);
      tx_exp.delete();
`endif
      if (rx_rden) begin
        cnt_rden++;
        chk("rden_dvalid", rx_fifo_dvalid, 1);
        chk("rden_gap", 32'((ncyc - last_rden) >= 4), 1);
`ifdef MON_RX_ECHO_EN
        chk("rden_during_echo", 32'(tx_exp.size() == 0), 1);
`endif
        last_rden = ncyc;
        model_byte(rx_rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
  endtask

  task automatic drain();
    int n = 0;
    tx_fifo_full = 1'b0;
    while ((fifo_q.size() != 0 || pop_pend || exp_q.size() != 0 || tx_exp.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("drain_timeout", 32'(n < 3000), 1);
  endtask

  function automatic logic [7:0] rand_byte();
    string hx = "0123456789abcdefABCDEF";
    int r = $urandom_range(0, 99);
    if (r < 45) return hx[$urandom_range(0, 21)];
    if (r < 65) begin
      r = $urandom_range(0, 2);
      return (r == 0) ? 8'h20 : (r == 1) ? 8'h0D : 8'h0A;
    end
    if (r < 80) return 8'($urandom_range(8'h21, 8'h7E));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rden"}, rx_rden, 0);
    chk({tag, "_wten"}, tx_wten, 0);
    chk({tag, "_wdata"}, tx_wdata, 0);
    chk({tag, "_word"}, data_word, 0);
    chk({tag, "_nd"}, data_ndigits, 0);
    chk({tag, "_cmd"}, cmd_char, 0);
    chk({tag, "_pulses"}, {data_valid, cmd_valid, line_end, parse_err}, 0);
  endtask

  // ---------------- main sequence ----------------
  int b_rden, b_dv, b_cv, b_pe, b_le, b_tx;

  task automatic snap();
    b_rden = cnt_rden; b_dv = cnt_dv; b_cv = cnt_cv; b_pe = cnt_pe; b_le = cnt_le; b_tx = cnt_tx;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3 chk_all_zero("reset");
    @(negedge clk);

    snap(); send("1A2b\r"); drain();
    chk("t1_rden", cnt_rden - b_rden, 5);
    chk("t1_dv", cnt_dv - b_dv, 1);
    chk("t1_word", last_word, 32'h00001A2B);
    chk("t1_nd", last_nd, 4);
    chk("t1_le_same", last_dv_le, 1);
    chk("t1_le", cnt_le - b_le, 1);

    snap(); send("123456789 "); drain();
    chk("t2_dv", cnt_dv - b_dv, 1);
    chk("t2_word", last_word, 32'h23456789);
    chk("t2_nd", last_nd, 8);

    snap(); send("12g"); drain();
    chk("t3_cv", cnt_cv - b_cv, 1);
    chk("t3_cmd", last_cmd, 8'h67);
    chk("t3_dv", cnt_dv - b_dv, 0);
    snap(); send(" "); drain();
    chk("t3_space_dv", cnt_dv - b_dv, 0);

    snap(); fifo_q.push_back(8'h07); send("5\n"); drain();
    chk("t4_pe", cnt_pe - b_pe, 1);
    chk("t4_dv", cnt_dv - b_dv, 1);
    chk("t4_word", last_word, 32'h5);
    chk("t4_nd", last_nd, 1);

`ifdef MON_RX_ECHO_EN
    tx_log.delete();
    snap(); tx_fifo_full = 1'b1; send("A\r");
    repeat (20) @(negedge clk);
    chk("t5_stall_tx", cnt_tx - b_tx, 0);
    chk("t5_stall_rden", cnt_rden - b_rden, 1);
    drain();
    chk("t5_tx_n", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("t5_tx0", tx_log[0], 8'h41);
      chk("t5_tx1", tx_log[1], 8'h0D);
      chk("t5_tx2", tx_log[2], 8'h0A);
    end

    // Reset while an echo is stalled; release full in the same cycle.
    tx_log.delete();
    tx_fifo_full = 1'b1; send("Z5 ");
    repeat (12) @(negedge clk);
    rst_n = 1'b0; tx_fifo_full = 1'b0;
    #3 chk("t6_wten_in_reset", tx_wten, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #3 chk_all_zero("t6_post_reset");
    snap(); drain();
    chk("t6_rden", cnt_rden - b_rden, 2);
    chk("t6_word", last_word, 32'h5);
    chk("t6_dv", cnt_dv - b_dv, 1);
    chk("t6_tx_n", tx_log.size(), 2);
    if (tx_log.size() == 2) chk("t6_tx0", tx_log[0], 8'h35);
`else
    // Reset during the pop cycle: no strobe, byte stays in the FIFO.
    send("Q7 ");
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #3 chk("t6_rden_in_reset", rx_rden, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #3 chk_all_zero("t6_post_reset");
    snap(); drain();
    chk("t6_rden", cnt_rden - b_rden, 3);
    chk("t6_cmd", last_cmd, 8'h51);
    chk("t6_word", last_word, 32'h7);
    chk("t6_nd", last_nd, 1);
`endif

    // Randomized byte stream with random transmit back-pressure.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      tx_fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(rand_byte());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
